// File: rtl/cv_pkg.sv
// Shared types, constants and helpers for the ColecoVision controller-port blocks.
package cv_pkg;

    typedef enum logic {SP_IDLE = 1'b0, SP_WAIT = 1'b1} sp_state_t;

    localparam logic [1:0] SP_PHASE_RESET = 2'b11;
    localparam int         SP_ACCEL_THR   = 64;

    // Adds a and b, then clamps the result to the symmetric range [-lim, +lim].
    function automatic int sat_add(input int a, input int b, input int lim);
        int s;
        s = a + b;
        if (s > lim) begin
            return lim;
        end else if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/cv_quad_gray.sv
// Two-bit quadrature phase register {A,B}: steps one Gray position per step_i.
// force_idle_i parks the pair at 11 and takes priority over stepping.
module cv_quad_gray
    import cv_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       step_i,
    input  logic       dir_i,
    input  logic       force_idle_i,
    output logic [1:0] phase_o
);

    logic [1:0] r_phase;
    logic       w_same;
    logic [1:0] w_toggle;

    // Forward flips B when A==B and A otherwise; reverse is the mirror image.
    assign w_same   = (r_phase[1] == r_phase[0]);
    assign w_toggle = (dir_i == w_same) ? 2'b01 : 2'b10;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_phase <= SP_PHASE_RESET;
        end else if (force_idle_i) begin
            r_phase <= SP_PHASE_RESET;
        end else if (step_i) begin
            r_phase <= r_phase ^ w_toggle;
        end
    end

    assign phase_o = r_phase;

endmodule

// File: rtl/cv_spinner_quad.sv
// Super Action spinner emulation: accumulates signed motion deltas and pays them out as
// rate-limited quadrature steps. Optional macro CV_SPINNER_ACCEL_EN enables 4x payout for |acc| >= 64.
module cv_spinner_quad
    import cv_pkg::*;
#(
    parameter int STEP_DIV = 1070,
    parameter int ACC_W    = 10
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clk_en_10m7_i,
    input  logic       enable_i,
    input  logic [7:0] delta_i,
    input  logic       delta_vld_i,
    output logic       p7_o,
    output logic       p9_o,
    output logic       busy_o,
    output logic       ovf_o
);

    localparam int          ACC_LIM = (1 << (ACC_W - 1)) - 1;
    localparam logic [15:0] TC_SLOW = 16'(STEP_DIV - 1);

    sp_state_t               r_state;
    sp_state_t               w_state_next;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [15:0]             r_timer;
    logic [15:0]             w_timer_next;
    logic [15:0]             w_tc;
    logic                    r_busy;
    logic                    r_ovf;
    logic                    w_step;
    logic                    w_dir;
    logic                    w_arm;
    logic                    w_ovf;
    int                      w_delta;
    int                      w_dir_val;
    int                      w_sum;
    int                      w_acc_sat;
    logic [1:0]              w_phase;

    // A step needs the timer at terminal count on an enable tick; sign of acc picks direction.
    assign w_step    = (r_state == SP_WAIT) && clk_en_10m7_i && (r_timer == w_tc) && (r_acc != '0);
    assign w_dir     = ~r_acc[ACC_W-1];
    assign w_delta   = delta_vld_i ? int'($signed(delta_i)) : 0;
    assign w_dir_val = w_step ? (w_dir ? 1 : -1) : 0;
    assign w_sum     = int'(r_acc) + w_delta - w_dir_val;
    assign w_acc_sat = sat_add(int'(r_acc), w_delta - w_dir_val, ACC_LIM);
    assign w_ovf     = (w_sum > ACC_LIM) || (w_sum < -ACC_LIM);
    assign w_acc_next = ACC_W'(w_acc_sat);
    assign w_arm     = (r_state == SP_IDLE) && (r_acc != '0) && (w_acc_next != '0);

`ifdef CV_SPINNER_ACCEL_EN
    localparam logic [15:0] TC_FAST = 16'((STEP_DIV >> 2) - 1);

    logic [15:0] r_tc;
    logic        w_big;

    // The payout rate is chosen only when the timer restarts, so a period is never cut short.
    assign w_big = (w_acc_sat >= SP_ACCEL_THR) || (w_acc_sat <= -SP_ACCEL_THR);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tc <= TC_SLOW;
        end else if (!enable_i) begin
            r_tc <= TC_SLOW;
        end else if (w_step || w_arm) begin
            r_tc <= w_big ? TC_FAST : TC_SLOW;
        end
    end

    assign w_tc = r_tc;
`else
    assign w_tc = TC_SLOW;
`endif

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        case (r_state)
            SP_IDLE: begin
                w_timer_next = '0;
                if (w_arm) begin
                    w_state_next = SP_WAIT;
                end
            end
            SP_WAIT: begin
                if (w_acc_next == '0) begin
                    w_state_next = SP_IDLE;
                    w_timer_next = '0;
                end else if (w_step) begin
                    w_timer_next = '0;
                end else if (clk_en_10m7_i) begin
                    w_timer_next = r_timer + 16'd1;
                end
            end
            default: begin
                w_state_next = SP_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= SP_IDLE;
            r_acc   <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (!enable_i) begin
            r_state <= SP_IDLE;
            r_acc   <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_timer <= w_timer_next;
            r_busy  <= (w_acc_next != '0);
            r_ovf   <= w_ovf;
        end
    end

    cv_quad_gray u_gray (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .step_i       (w_step),
        .dir_i        (w_dir),
        .force_idle_i (~enable_i),
        .phase_o      (w_phase)
    );

    assign p7_o   = w_phase[1];
    assign p9_o   = w_phase[0];
    assign busy_o = r_busy;
    assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_cv_spinner_quad.sv
// Scoreboard bench for cv_spinner_quad: a behavioural model predicts every phase edge and
// overflow pulse with its cycle; a monitor pops and compares whenever the DUT shows one.
`timescale 1ns/1ps
module tb_cv_spinner_quad;

    localparam int STEP_DIV = 4;
    localparam int ACC_W    = 10;
    localparam int LIM      = 511;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       clk_en    = 1'b0;
    logic       enable    = 1'b0;
    logic       delta_vld = 1'b0;
    logic [7:0] delta     = 8'd0;
    logic       p7, p9, busy, ovf;

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int mon_edges = 0;
    int mon_ovfs  = 0;

    typedef struct { logic [1:0] ph; int at; } edge_t;
    edge_t edge_q[$];
    int    ovf_q[$];

    // Forward Gray order; reverse walks it backwards.
    logic [1:0] ph_tab [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

    // Reference model: integer accumulator, tick counter since last restart, phase index.
    int m_acc   = 0;
    int m_ticks = 0;
    int m_tc    = STEP_DIV - 1;
    int m_idx   = 0;
    bit m_armed = 1'b0;

    cv_spinner_quad #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .clk_en_10m7_i (clk_en),
        .enable_i      (enable),
        .delta_i       (delta),
        .delta_vld_i   (delta_vld),
        .p7_o          (p7),
        .p9_o          (p9),
        .busy_o        (busy),
        .ovf_o         (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit model_step_now();
        return m_armed && clk_en && (m_ticks == m_tc) && (m_acc != 0);
    endfunction

    task automatic model_cycle();
        int d, dir, sum, nxt, new_tc;
        bit step;
        if (!enable) begin
            if (m_idx != 0) edge_q.push_back(edge_t'{ph_tab[0], cyc + 1});
            m_acc = 0; m_armed = 0; m_ticks = 0; m_idx = 0; m_tc = STEP_DIV - 1;
            return;
        end
        step = model_step_now();
        dir  = step ? ((m_acc > 0) ? 1 : -1) : 0;
        d    = delta_vld ? int'($signed(delta)) : 0;
        sum  = m_acc + d - dir;
        nxt  = (sum > LIM) ? LIM : ((sum < -LIM) ? -LIM : sum);
        new_tc = STEP_DIV - 1;
`ifdef CV_SPINNER_ACCEL_EN
        if (nxt >= 64 || nxt <= -64) new_tc = (STEP_DIV >> 2) - 1;
`endif
        if (sum != nxt) ovf_q.push_back(cyc + 1);
        if (step) begin
            m_idx = (m_idx + dir + 4) % 4;
            edge_q.push_back(edge_t'{ph_tab[m_idx], cyc + 1});
        end
        if (!m_armed) begin
            if (m_acc != 0 && nxt != 0) begin m_armed = 1; m_ticks = 0; m_tc = new_tc; end
        end else if (nxt == 0) begin
            m_armed = 0; m_ticks = 0;
        end else if (step) begin
            m_ticks = 0; m_tc = new_tc;
        end else if (clk_en) begin
            m_ticks++;
        end
        m_acc = nxt;
    endtask

    // One clock cycle of stimulus; strobes last exactly one cycle.
    task automatic run_cycle();
        clk_en = ((cyc % 4) == 0);
        model_cycle();
        @(posedge clk);
        #1;
        delta_vld = 1'b0;
    endtask

    task automatic strobe(input int d);
        delta = 8'(d); delta_vld = 1'b1;
        run_cycle();
    endtask

    task automatic reidle();
        enable = 1'b0; run_cycle();
        enable = 1'b1; run_cycle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((m_acc != 0 || m_armed || busy) && n < 12000) begin run_cycle(); n++; end
        check({tag, "_drain_in_budget"}, int'(n < 12000), 1);
        repeat (3) run_cycle();
        check({tag, "_busy_idle"}, int'(busy), 0);
        check({tag, "_final_phase"}, int'({p7, p9}), int'(ph_tab[m_idx]));
        check({tag, "_edges_pending"}, edge_q.size(), 0);
        check({tag, "_ovf_pending"}, ovf_q.size(), 0);
    endtask

    // Monitor: every observed phase change or overflow pulse is matched against the scoreboard.
    logic [1:0] mon_prev = 2'b11;
    edge_t      mon_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_prev = 2'b11;
        end else begin
            if ({p7, p9} != mon_prev) begin
                mon_edges++;
                if (edge_q.size() == 0) begin
                    check("unexpected_edge", int'({p7, p9}), int'(mon_prev));
                end else begin
                    mon_e = edge_q.pop_front();
                    check("edge_phase", int'({p7, p9}), int'(mon_e.ph));
                    check("edge_cycle", cyc, mon_e.at);
                end
                mon_prev = {p7, p9};
            end
            if (ovf) begin
                mon_ovfs++;
                if (ovf_q.size() == 0) check("unexpected_ovf", 1, 0);
                else check("ovf_cycle", cyc, ovf_q.pop_front());
            end
        end
    end

    initial begin
        int e0, o0, n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_phase", int'({p7, p9}), 3);
        check("reset_busy", int'(busy), 0);
        check("reset_ovf", int'(ovf), 0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Idle: no edges for 1000 cycles.
        e0 = mon_edges;
        repeat (1000) run_cycle();
        check("s1_no_edges", mon_edges - e0, 0);
        check("s1_phase", int'({p7, p9}), 3);

        // +3: three forward edges.
        e0 = mon_edges;
        strobe(3);
        check("s2_busy_next_cycle", int'(busy), 1);
        drain("s2");
        check("s2_edges", mon_edges - e0, 3);
        check("s2_phase_01", int'({p7, p9}), 1);

        // -2: two reverse edges from 11.
        reidle();
        e0 = mon_edges;
        strobe(-2);
        drain("s3");
        check("s3_edges", mon_edges - e0, 2);
        check("s3_phase_00", int'({p7, p9}), 0);

        // Saturation: 5 x +127.
        reidle();
        e0 = mon_edges; o0 = mon_ovfs;
        repeat (5) strobe(127);
        check("s4_ovf_pulse", int'(ovf), 1);
        drain("s4");
        check("s4_edges", mon_edges - e0, 511);
        check("s4_ovf_count", mon_ovfs - o0, 1);

        // Delta of -5 landing on a forward step with acc = +5.
        reidle();
        e0 = mon_edges;
        strobe(5);
        n = 0;
        clk_en = ((cyc % 4) == 0);
        while (!model_step_now() && n < 200) begin
            run_cycle(); n++;
            clk_en = ((cyc % 4) == 0);
        end
        check("s5_step_found", int'(n < 200), 1);
        strobe(-5);
        check("s5_busy_after_combine", int'(busy), 1);
        drain("s5");
        check("s5_edges", mon_edges - e0, 2);
        check("s5_phase_back_11", int'({p7, p9}), 3);

        // Enable drop mid-payout.
        reidle();
        strobe(40);
        repeat (100) run_cycle();
        enable = 1'b0;
        run_cycle();
        check("s6_phase_forced", int'({p7, p9}), 3);
        check("s6_busy_cleared", int'(busy), 0);
        repeat (5) strobe(50);
        repeat (5) run_cycle();
        enable = 1'b1;
        e0 = mon_edges;
        repeat (1000) run_cycle();
        check("s6_no_edges", mon_edges - e0, 0);
        check("s6_busy", int'(busy), 0);
        strobe(2);
        drain("s6");
        check("s6_new_edges", mon_edges - e0, 2);

`ifdef CV_SPINNER_ACCEL_EN
        reidle();
        e0 = mon_edges;
        strobe(100);
        drain("s7");
        check("s7_edges", mon_edges - e0, 100);
`endif

        // Randomised traffic with occasional enable drops.
        reidle();
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 299) != 0);
            delta     = 8'($urandom);
            delta_vld = ($urandom_range(0, 31) == 0);
            run_cycle();
        end
        enable = 1'b1;
        drain("rnd");

        // Asynchronous reset mid-payout returns outputs to 11 without a clock edge.
        strobe(5);
        n = 0;
        while ((m_idx == 0 || edge_q.size() != 0) && n < 500) begin run_cycle(); n++; end
        check("ar_reached_step", int'(n < 500), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_phase", int'({p7, p9}), 3);
        check("ar_busy", int'(busy), 0);
        edge_q.delete();
        ovf_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
